// File: rtl/fir_out_decim_pkg.sv
// Shared definitions for the FIR filter and its output decimator.
// Holds the filter geometry and the sample type.
package fir_out_decim_pkg;

    localparam int FIR_WIDTH = 24;
    localparam int FIR_FRAME = 128;

    typedef logic signed [FIR_WIDTH-1:0] sample_t;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/fir_out_decim_sync_fifo.sv
// Small synchronous FIFO with a registered head-of-queue output.
// dout always shows the oldest entry and holds its last value when empty.
module sync_fifo
    import fir_out_decim_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             w_pop;
    logic             w_push;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_pop  = pop && !empty;
    // A full FIFO still accepts a push when the same edge frees a slot
    assign w_push = push && (!full || w_pop);
    assign dout   = r_dout;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push && (empty || (w_pop && r_count == CW'(1)))) begin
                r_dout <= din;
            end else if (w_pop && r_count > CW'(1)) begin
                r_dout <= r_mem[ptr_next(r_rd_ptr)];
            end
        end
    end

endmodule

// File: rtl/fir_out_decim.sv
// Captures one FIR result per frame, keeps every DECIM-th one and
// queues it for a valid/ready consumer, counting samples lost to a full queue.
module fir_out_decim
    import fir_out_decim_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int FRAME = FIR_FRAME,
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ready,
    input  logic signed [WIDTH-1:0] filtred_sig,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overflow,
    output logic [7:0]              drop_cnt
);

    localparam int FW = clog2_min1(FRAME);
    localparam int DW = clog2_min1(DECIM);

    logic [FW-1:0]    r_frame_cnt;
    logic             r_strobe;
    logic [DW-1:0]    r_dec_cnt;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;
    logic             w_frame_end;
    logic             w_keep;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_dout;

    assign w_frame_end = ready && (r_frame_cnt == FW'(FRAME - 1));
    assign w_keep      = r_strobe && (r_dec_cnt == '0);
    assign w_drop      = w_keep && w_full && !out_ready;

    assign out_valid = !w_empty;
    assign out_data  = w_dout;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

    // Counter starts at FRAME-1 so its wrap lines up with the filter result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= FW'(FRAME - 1);
            r_strobe    <= 1'b0;
        end else begin
            r_strobe <= w_frame_end;
            if (w_frame_end) begin
                r_frame_cnt <= '0;
            end else if (ready) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec_cnt <= '0;
        end else if (r_strobe) begin
            r_dec_cnt <= (r_dec_cnt == DW'(DECIM - 1)) ? '0 : r_dec_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_keep),
        .pop   (out_ready),
        .din   (filtred_sig),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

endmodule

// File: tb/tb_fir_out_decim.sv
// Directed bench for fir_out_decim: frame timing, decimation,
// FIFO overflow, full push+pop and asynchronous reset.
module tb_fir_out_decim;
    import fir_out_decim_pkg::*;

    localparam int JUNK = 24'h5A5A5A;

    typedef struct {
        int sig;
        bit kept;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready;
    sample_t       filtred_sig;
    sample_t       out_data;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;
    logic [7:0]    drop_cnt;

    int total = 0;
    int bad   = 0;
    int n_pop = 0;

    fir_out_decim #(
        .WIDTH (FIR_WIDTH),
        .FRAME (FIR_FRAME),
        .DECIM (4),
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .filtred_sig (filtred_sig),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) n_pop++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        ready = 1'b0;
        out_ready = 1'b0;
        filtred_sig = sample_t'(JUNK);
        tick();
        tick();
        rst = 1'b0;
    endtask

    vec_t tbl [12];
    int   base, t1, t2;
    logic [31:0] d1, d2;

    initial begin
        tbl = '{'{0, 1}, '{1, 0}, '{2, 0}, '{3, 0},
                '{4, 1}, '{-1, 0}, '{6, 0}, '{7, 0},
                '{-8388608, 1}, '{9, 0}, '{10, 0}, '{11, 0}};

        rst = 1'b1;
        ready = 1'b0;
        out_ready = 1'b0;
        filtred_sig = '0;
        repeat (3) tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_drop", 32'(drop_cnt), 0);

        // first frame end on first ready cycle, push one cycle later
        ready = 1'b1;
        filtred_sig = 24'sd55;
        rst = 1'b0;
        tick();
        check("lat_valid_e1", 32'(out_valid), 0);
        filtred_sig = 24'sd100;
        tick();
        check("lat_valid_e2", 32'(out_valid), 1);
        check("lat_data_e2", out_data, 100);
        filtred_sig = 24'sd55;
        tick();
        check("lat_hold", out_data, 100);

        // table-driven frames, DECIM=4 keeps frames 0,4,8
        do_reset();
        ready = 1'b1;
        out_ready = 1'b1;
        base = n_pop;
        for (int i = 0; i < 12; i++) begin
            tick();
            filtred_sig = sample_t'(tbl[i].sig);
            tick();
            filtred_sig = sample_t'(JUNK);
            check($sformatf("tbl%0d_valid", i), 32'(out_valid),
                  32'(tbl[i].kept));
            if (tbl[i].kept)
                check($sformatf("tbl%0d_data", i), out_data,
                      32'(tbl[i].sig));
            tick();
            check($sformatf("tbl%0d_popped", i), 32'(out_valid), 0);
            repeat (125) tick();
        end
        check("tbl_npop", 32'(n_pop - base), 3);
        check("tbl_ovf", 32'(overflow), 0);

        // ready at 50% duty: frame end every 256 clocks
        do_reset();
        out_ready = 1'b1;
        t1 = 0;
        t2 = 0;
        d1 = '0;
        d2 = '0;
        for (int n = 1; n <= 1100; n++) begin
            ready = n[0];
            filtred_sig = sample_t'(n);
            tick();
            if (out_valid) begin
                if (t1 == 0) begin
                    t1 = n;
                    d1 = out_data;
                end else if (t2 == 0) begin
                    t2 = n;
                    d2 = out_data;
                end
            end
        end
        check("duty_t1", t1, 2);
        check("duty_d1", d1, 2);
        check("duty_t2", t2, 1026);
        check("duty_d2", d2, 1026);

        // overflow: 6 kept samples, no consumer
        do_reset();
        ready = 1'b1;
        for (int n = 1; n <= 2600; n++) begin
            filtred_sig = sample_t'(1000 + (n - 2) / 128);
            tick();
        end
        ready = 1'b0;
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_drop", 32'(drop_cnt), 2);
        check("ovf_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_rd%0d", i), out_data, 1000 + 4 * i);
            tick();
        end
        check("ovf_empty", 32'(out_valid), 0);
        check("ovf_hold", out_data, 1012);
        out_ready = 1'b0;

        // full FIFO with push and pop on the same edge
        do_reset();
        ready = 1'b1;
        for (int n = 1; n <= 2060; n++) begin
            filtred_sig = sample_t'(2000 + (n - 2) / 128);
            out_ready = (n == 2050);
            tick();
        end
        ready = 1'b0;
        out_ready = 1'b0;
        check("pp_ovf", 32'(overflow), 0);
        check("pp_drop", 32'(drop_cnt), 0);
        check("pp_head", out_data, 2004);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pp_valid%0d", i), 32'(out_valid), 1);
            check($sformatf("pp_rd%0d", i), out_data, 2004 + 4 * i);
            tick();
        end
        check("pp_empty", 32'(out_valid), 0);
        out_ready = 1'b0;

        // asynchronous reset with samples queued
        do_reset();
        ready = 1'b1;
        filtred_sig = 24'sd3000;
        for (int n = 1; n <= 1100; n++) tick();
        check("ar_queued", 32'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(out_valid), 0);
        check("ar_data", out_data, 0);
        check("ar_drop", 32'(drop_cnt), 0);
        tick();
        tick();
        rst = 1'b0;
        filtred_sig = 24'sd77;
        tick();
        check("ar_e1", 32'(out_valid), 0);
        tick();
        check("ar_e2", 32'(out_valid), 1);
        check("ar_data2", out_data, 77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
